// File: rtl/demux_latch_pkg.sv
// Shared types for the addressable demultiplexing latch: mode encoding and decode helper.
package demux_latch_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 3;

    // Encoding matches {g_n, clr_n} so the decode is a straight relabel
    typedef enum logic [1:0] {
        MODE_DEMUX = 2'b00,
        MODE_WRITE = 2'b01,
        MODE_CLEAR = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

    function automatic mode_e decode_mode(input logic g_n, input logic clr_n);
        mode_e m;
        case ({g_n, clr_n})
            2'b00:   m = MODE_DEMUX;
            2'b01:   m = MODE_WRITE;
            2'b10:   m = MODE_CLEAR;
            default: m = MODE_HOLD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/demux_ptr_counter.sv
// Wrapping auto-increment pointer; o_wrap_c flags the edge that will roll N-1 over to 0.
module demux_ptr_counter
    import demux_latch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_inc,
    input  logic              i_clr,
    output logic [ADDR_W-1:0] o_count,
    output logic              o_wrap_c
);

    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    logic [ADDR_W-1:0] r_count;

    // Clear outranks increment, so a clear on the last slot never reports a wrap
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + ADDR_W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_wrap_c = i_inc && !i_clr && (r_count == CNT_MAX);

endmodule

// File: rtl/demux_latch.sv
// Clocked 1-to-N addressable latch with write/hold/demux/clear modes and an auto-increment pointer.
module demux_latch
    import demux_latch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     g_n,
    input  logic                     clr_n,
    input  logic                     d,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     auto_inc,
    output logic [(1<<ADDR_W)-1:0]   q,
    output logic [ADDR_W-1:0]        ptr,
    output logic                     full
);

    localparam int unsigned N = 1 << ADDR_W;

    mode_e             w_mode;
    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] w_ea;
    logic [N-1:0]      w_sel;
    logic [N-1:0]      w_q_next;
    logic              w_inc;
    logic              w_clr;
    logic              w_wrap;

    logic [N-1:0]      r_q;
    logic              r_full;

    assign w_mode = decode_mode(g_n, clr_n);
    assign w_ea   = auto_inc ? w_ptr : addr;
    assign w_inc  = auto_inc && ((w_mode == MODE_WRITE) || (w_mode == MODE_DEMUX));
    assign w_clr  = (w_mode == MODE_CLEAR);

    demux_ptr_counter #(
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk      (clk),
        .i_rst    (rst),
        .i_inc    (w_inc),
        .i_clr    (w_clr),
        .o_count  (w_ptr),
        .o_wrap_c (w_wrap)
    );

    // One-hot select of the targeted output bit
    always_comb begin
        w_sel       = '0;
        w_sel[w_ea] = 1'b1;
    end

    always_comb begin
        w_q_next = r_q;
        case (w_mode)
            MODE_WRITE: w_q_next = (r_q & ~w_sel) | ({N{d}} & w_sel);
            MODE_DEMUX: w_q_next = {N{d}} & w_sel;
            MODE_CLEAR: w_q_next = '0;
            default:    w_q_next = r_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    // Sticky wrap flag; only a clear or reset drops it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
        end else if (w_clr) begin
            r_full <= 1'b0;
        end else if (w_wrap) begin
            r_full <= 1'b1;
        end
    end

    assign q    = r_q;
    assign ptr  = w_ptr;
    assign full = r_full;

endmodule

// File: tb/tb_demux_latch.sv
// Directed table-driven bench for demux_latch (ADDR_W = 3, N = 8).
module tb_demux_latch;

    logic       clk;
    logic       rst;
    logic       g_n;
    logic       clr_n;
    logic       d;
    logic [2:0] addr;
    logic       auto_inc;
    logic [7:0] q;
    logic [2:0] ptr;
    logic       full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       g_n;
        logic       clr_n;
        logic       d;
        logic [2:0] addr;
        logic       ai;
        logic [7:0] eq;
        logic [2:0] eptr;
        logic       efull;
    } vec_t;

    vec_t vecs[$];

    demux_latch dut (
        .clk      (clk),
        .rst      (rst),
        .g_n      (g_n),
        .clr_n    (clr_n),
        .d        (d),
        .addr     (addr),
        .auto_inc (auto_inc),
        .q        (q),
        .ptr      (ptr),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode shorthands as {g_n, clr_n}: W=01 H=11 D=00 C=10
    function automatic void add(input logic r, input logic [1:0] m, input logic dd,
                                input logic [2:0] a, input logic ai,
                                input logic [7:0] eq, input logic [2:0] ep, input logic ef);
        vec_t v;
        v.rst = r; v.g_n = m[1]; v.clr_n = m[0]; v.d = dd; v.addr = a; v.ai = ai;
        v.eq = eq; v.eptr = ep; v.efull = ef;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic gn, input logic cn, input logic dd,
                         input logic [2:0] a, input logic ai);
        @(negedge clk);
        rst = r; g_n = gn; clr_n = cn; d = dd; addr = a; auto_inc = ai;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] eq, input logic [2:0] ep, input logic ef);
        checks++;
        if (q !== eq || ptr !== ep || full !== ef) begin
            errors++;
            $display("FAIL %s: got q=%h ptr=%0d full=%b, expected q=%h ptr=%0d full=%b",
                     name, q, ptr, full, eq, ep, ef);
        end
    endtask

    localparam logic [1:0] W = 2'b01, H = 2'b11, D = 2'b00, C = 2'b10;

    initial begin
        rst = 1'b1; g_n = 1'b1; clr_n = 1'b1; d = 1'b0; addr = 3'd0; auto_inc = 1'b0;

        add(1, H, 0, 0, 0, 8'h00, 0, 0);          // reset
        add(0, W, 1, 5, 0, 8'h20, 0, 0);          // write addr 5
        add(0, H, 0, 5, 1, 8'h20, 0, 0);          // hold ignores everything
        add(0, H, 1, 2, 0, 8'h20, 0, 0);
        add(0, H, 1, 7, 1, 8'h20, 0, 0);
        add(0, W, 1, 0, 0, 8'h21, 0, 0);          // fill to FF
        add(0, W, 1, 1, 0, 8'h23, 0, 0);
        add(0, W, 1, 2, 0, 8'h27, 0, 0);
        add(0, W, 1, 3, 0, 8'h2F, 0, 0);
        add(0, W, 1, 4, 0, 8'h3F, 0, 0);
        add(0, W, 1, 6, 0, 8'h7F, 0, 0);
        add(0, W, 1, 7, 0, 8'hFF, 0, 0);
        add(0, D, 1, 2, 0, 8'h04, 0, 0);          // demux one-hot
        add(0, D, 0, 7, 0, 8'h00, 0, 0);          // demux with d=0
        add(0, W, 1, 0, 1, 8'h01, 1, 0);          // serial 1,0,1,1,0,0,1,0
        add(0, W, 0, 0, 1, 8'h01, 2, 0);
        add(0, W, 1, 0, 1, 8'h05, 3, 0);
        add(0, W, 1, 0, 1, 8'h0D, 4, 0);
        add(0, W, 0, 0, 1, 8'h0D, 5, 0);
        add(0, W, 0, 0, 1, 8'h0D, 6, 0);
        add(0, W, 1, 0, 1, 8'h4D, 7, 0);
        add(0, W, 0, 0, 1, 8'h4D, 0, 1);          // wrap sets full
        add(0, W, 1, 0, 1, 8'h4D, 1, 1);          // 9th write
        add(0, W, 0, 0, 1, 8'h4D, 2, 1);
        add(0, W, 0, 0, 1, 8'h49, 3, 1);          // clears bit 2
        add(0, C, 1, 6, 1, 8'h00, 0, 0);          // clear
        add(0, W, 1, 0, 1, 8'h01, 1, 0);
        add(0, C, 0, 0, 0, 8'h00, 0, 0);
        add(0, W, 1, 0, 1, 8'h01, 1, 0);          // 4 writes -> 0F, ptr 4
        add(0, W, 1, 0, 1, 8'h03, 2, 0);
        add(0, W, 1, 0, 1, 8'h07, 3, 0);
        add(0, W, 1, 0, 1, 8'h0F, 4, 0);
        add(1, W, 1, 0, 1, 8'h00, 0, 0);          // mid-stream reset
        add(0, W, 0, 0, 1, 8'h00, 1, 0);
        add(0, W, 0, 0, 1, 8'h00, 2, 0);
        add(0, W, 0, 0, 1, 8'h00, 3, 0);
        add(0, W, 0, 0, 1, 8'h00, 4, 0);
        add(0, W, 0, 0, 1, 8'h00, 5, 0);
        add(0, W, 0, 0, 1, 8'h00, 6, 0);
        add(0, W, 1, 1, 0, 8'h02, 6, 0);          // auto_inc off: addr used, ptr kept
        add(0, W, 1, 1, 1, 8'h42, 7, 0);          // resumes from 6
        add(0, C, 1, 0, 1, 8'h00, 0, 0);          // clear at ptr 7 beats wrap
        add(0, W, 1, 3, 0, 8'h08, 0, 0);          // same address twice
        add(0, W, 0, 3, 0, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].g_n, vecs[i].clr_n, vecs[i].d, vecs[i].addr, vecs[i].ai);
            check($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eptr, vecs[i].efull);
        end

        // Demux sweep in auto-increment: one-hot walks, wrap sets full in DEMUX mode
        for (int i = 0; i < 8; i++) begin
            logic [7:0] eq;
            eq = 8'h01 << i;
            drive(0, 0, 0, 1, 3'(7 - i), 1);
            check($sformatf("demux_walk%0d", i), eq, 3'(i + 1), (i == 7));
        end

        // Random hold cycles keep the full state intact
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(1)));
            check($sformatf("hold_rand%0d", i), 8'h80, 0, 1);
        end

        // Reset while full is set
        drive(1, 1, 0, 1, 3, 1);
        check("rst_full", 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_latch.md
Name: demux_latch

Overview:
- Clocked 1-to-N addressable demultiplexing latch: the inverse of the quad 2-to-1 select path.
- Routes a single data bit to one of N stored outputs selected by an address.
- Supports an auto-increment mode, so a serial bit stream is deserialised into the output word.
- Used in the TTL simulation library wherever a control bit must be fanned out and held, e.g. flag/strobe registers, and as a clocked stand-in for a 74LS259-style part.

Parameters:
- ADDR_W, 3: address width. The number of outputs N = 2**ADDR_W is a derived localparam, not overridable. Legal range 1..5.

Ports:
- clk  input  1  rising-edge clock; the single clock domain.
- rst  input  1  synchronous reset, active-high.
- g_n  input  1  active-low enable.
- clr_n  input  1  active-low clear/demux select; combines with g_n to form the mode.
- d  input  1  data bit to route.
- addr  input  ADDR_W  external target index.
- auto_inc  input  1  1 = use internal pointer instead of addr.
- q  output  N  latched outputs; q[i] is output i.
- ptr  output  ADDR_W  current internal pointer value.
- full  output  1  sticky flag: pointer has wrapped since last clear/reset.

Behaviour:
- All state updates on the rising clk edge only. Inputs are sampled at the edge. No combinational path from any input to any output.
- Reset: rst=1 at an edge forces q=0, ptr=0, full=0. Reset overrides every mode, including reset asserted mid-stream.
- Effective address: ea = auto_inc ? ptr : addr.
- Mode from {g_n, clr_n}:
  - 0,1 WRITE: q[ea] <= d; all other bits hold.
  - 1,1 HOLD: q, ptr and full unchanged; d, addr and auto_inc ignored.
  - 0,0 DEMUX: q[ea] <= d; all other bits <= 0 (one-hot, or all-zero when d=0).
  - 1,0 CLEAR: q <= 0, ptr <= 0, full <= 0.
- Pointer:
  - Advances by 1 at an edge in WRITE or DEMUX mode when auto_inc=1.
  - Holds when auto_inc=0, in HOLD, or in CLEAR (CLEAR zeroes it).
  - Width ADDR_W, modulo N. N-1 wraps to 0.
- full:
  - Set to 1 on the edge where ptr advances from N-1 to 0.
  - Stays 1 until CLEAR or rst.
  - If the wrap and CLEAR coincide, CLEAR wins (it is the mode, so no advance occurs).
- Switching auto_inc:
  - 1 to 0: ptr retains its value.
  - 0 to 1: the pointer resumes from the retained value, not from addr.
- Latency: a write at edge k is visible on q, ptr and full after edge k. One-cycle latency, back-to-back writes every cycle allowed.
- Same address written in consecutive cycles: the last write wins.
- No X propagation requirements. Inputs are assumed driven; the bench must not drive X.

Decomposition:
- Shared package demux_latch_pkg:
  - 2-bit mode enum (MODE_WRITE, MODE_HOLD, MODE_DEMUX, MODE_CLEAR).
  - Decode function mapping {g_n, clr_n} to the mode.
  - Default ADDR_W constant.
- One sub-module, demux_ptr_counter:
  - ADDR_W-bit wrapping counter with inc and clr inputs.
  - Outputs: count and a wrap pulse; full is registered in the parent from the wrap pulse.
- The output register and per-bit write decode live in the top.

Test Plan:
- Reset, then WRITE with auto_inc=0, addr=5, d=1 -> q=8'h20, ptr=0, full=0 after one edge. Then HOLD for 3 cycles with random d/addr -> q stays 8'h20.
- DEMUX with addr=2, d=1 applied to q=8'hFF -> q=8'h04. Then DEMUX with addr=7, d=0 -> q=8'h00.
- auto_inc=1, WRITE, serial d = 1,0,1,1,0,0,1,0 over 8 cycles from ptr=0 -> q=8'h4D, ptr=0, full=1 after the 8th edge. A 9th write with d=1 -> q=8'h4D, q[0] stays 1, ptr=1, full stays 1.
- With full=1 and ptr=3, drive CLEAR for one cycle -> q=0, ptr=0, full=0. Then WRITE with auto_inc=1 -> ptr=1.
- Mid-stream reset: after 4 auto-increment writes (ptr=4, q=8'h0F), assert rst for one edge together with WRITE -> q=0, ptr=0, full=0. The write is discarded.
- auto_inc toggling: ptr=6, auto_inc=0, WRITE addr=1, d=1 -> q[1]=1, ptr stays 6. Then auto_inc=1, WRITE d=1 -> q[6]=1, ptr=7.
